pwm_dac_multi: RTL

Multi-channel PWM / sigma-delta DAC for the audio output path, driven by one shared period counter. Each channel takes a WIDTH-bit sample and produces a 1-bit output. Samples are double-buffered and applied only at period boundaries, so an update never glitches a period. A block-wide mode selects classic PWM or first-order sigma-delta. The block sits between the audio mixer and the board's RC-filtered output pins.

---
 rtl/pwm_dac_if.sv | 25 ++
 rtl/pwm_dac_multi.sv | 120 ++++++++++++
 2 files changed

// File: rtl/pwm_dac_if.sv
// Sample/control bus into the multi-channel PWM / sigma-delta DAC and
// the registered 1-bit outputs coming back out of it.
interface pwm_dac_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  logic [CHANNELS*WIDTH-1:0] digital_in;
  logic                      load;
  logic                      mode;
  logic [CHANNELS-1:0]       enable;
  logic [CHANNELS-1:0]       pwm;
  logic                      period_start;

  // Mixer side drives samples and controls.
  modport master (
    output digital_in, load, mode, enable,
    input  pwm, period_start
  );

  // DAC side consumes samples and drives the pins.
  modport slave (
    input  digital_in, load, mode, enable,
    output pwm, period_start
  );
endinterface

// File: rtl/pwm_dac_multi.sv
// pwm_dac_multi: CHANNELS independent 1-bit DAC outputs sharing one
// 2^WIDTH-cycle period counter. Samples are double-buffered (shadow ->
// active) and everything the outputs depend on is swapped only at the
// last cycle of a period, so a period is never cut short or glitched.

// One output channel: PWM compare or first-order sigma-delta.
module pwm_dac_lane #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_cnt,
  input  logic [WIDTH-1:0] i_active,
  input  logic             i_en,
  input  logic             i_mode,
  input  logic             i_acc_clr,
  output logic             o_pwm
);
  logic [WIDTH-1:0] r_acc;
  logic             r_pwm;
  logic [WIDTH:0]   w_sum;

  // Carry out of the accumulator is the sigma-delta bit.
  assign w_sum = {1'b0, r_acc} + {1'b0, i_active};

  // Output bit and accumulator; a disabled lane parks its accumulator at 0
  // so re-enabling always starts the sigma-delta pattern from a clean phase.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_pwm <= 1'b0;
    end else begin
      if (!i_en)       r_pwm <= 1'b0;
      else if (i_mode) r_pwm <= w_sum[WIDTH];
      else             r_pwm <= (i_cnt < i_active);

      if (i_acc_clr || !i_en) r_acc <= '0;
      else if (i_mode)        r_acc <= w_sum[WIDTH-1:0];
    end
  end

  assign o_pwm = r_pwm;
endmodule

module pwm_dac_multi #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  pwm_dac_if.slave  bus
);
  logic [WIDTH-1:0]                 r_cnt;
  logic [CHANNELS-1:0][WIDTH-1:0]   r_shadow;
  logic [CHANNELS-1:0][WIDTH-1:0]   r_active;
  logic                             r_mode_act;
  logic [CHANNELS-1:0]              r_en_act;
  logic                             r_period_start;

  logic [CHANNELS-1:0][WIDTH-1:0]   w_din;
  logic                             w_boundary;
  logic                             w_acc_clr;
  logic [CHANNELS-1:0]              w_pwm;

  // Channel i sits at digital_in[i*WIDTH +: WIDTH]; the packed 2-D view
  // has exactly the same bit layout.
  assign w_din      = bus.digital_in;
  assign w_boundary = (r_cnt == '1);
  // Switching modes restarts every accumulator so the new mode begins
  // from a known phase.
  assign w_acc_clr  = w_boundary && (bus.mode != r_mode_act);

  // Free-running period counter, wraps naturally at 2^WIDTH.
  always_ff @(posedge clk) begin
    if (!rst_n) r_cnt <= '0;
    else        r_cnt <= r_cnt + WIDTH'(1);
  end

  // Shadow buffer: any load overwrites it; the running period never sees it.
  always_ff @(posedge clk) begin
    if (!rst_n)        r_shadow <= '0;
    else if (bus.load) r_shadow <= w_din;
  end

  // Period-boundary swap; a load in the boundary cycle bypasses the shadow
  // so the newest sample is not delayed a whole period.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_active   <= '0;
      r_mode_act <= 1'b0;
      r_en_act   <= '0;
    end else if (w_boundary) begin
      r_active   <= bus.load ? w_din : r_shadow;
      r_mode_act <= bus.mode;
      r_en_act   <= bus.enable;
    end
  end

  // Marks the first output cycle of each period, aligned with the lane outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) r_period_start <= 1'b0;
    else        r_period_start <= (r_cnt == '0);
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    pwm_dac_lane #(.WIDTH(WIDTH)) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_cnt     (r_cnt),
      .i_active  (r_active[g]),
      .i_en      (r_en_act[g]),
      .i_mode    (r_mode_act),
      .i_acc_clr (w_acc_clr),
      .o_pwm     (w_pwm[g])
    );
  end

  assign bus.pwm          = w_pwm;
  assign bus.period_start = r_period_start;
endmodule
